// File: rtl/uart_tx_arb.sv
// Two-requester UART transmitter: round-robin grant in IDLE, then one 8N1/8E1
// frame on tx, with bit timing from a baud-enable counter on inp_clk.
module uart_tx_arb #(
  parameter int CLKS_PER_BIT = 8,
  parameter bit PARITY_EN    = 1'b0
) (
  input  logic       inp_clk,
  input  logic       rst,
  input  logic       req0_valid,
  input  logic [7:0] req0_data,
  output logic       req0_ready,
  input  logic       req1_valid,
  input  logic [7:0] req1_data,
  output logic       req1_ready,
  output logic       tx,
  output logic       busy,
  output logic       grant_id,
  output logic [2:0] o_dbg_state
);

  localparam int CW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] BAUD_LAST = CW'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } state_t;

  state_t        r_state, w_nxt_state;
  logic [CW-1:0] r_baud, w_nxt_baud;
  logic [2:0]    r_bit, w_nxt_bit;
  logic [7:0]    r_shift, w_nxt_shift;
  logic          r_par, w_nxt_par;
  logic          r_rr, w_nxt_rr;
  logic          r_tx, w_nxt_tx;
  logic          r_busy, w_nxt_busy;
  logic          r_gid, w_nxt_gid;

  logic          w_idle, w_any, w_sel, w_bit_end;
  logic [7:0]    w_sel_data;

  // Handshake: a byte moves on a rising edge where valid && ready. Ready is a
  // combinational grant, only ever raised in IDLE, never while rst is high.
  assign w_idle     = (r_state == S_IDLE);
  assign w_any      = req0_valid | req1_valid;
  assign w_sel      = (req0_valid & req1_valid) ? r_rr : req1_valid;
  assign w_sel_data = w_sel ? req1_data : req0_data;
  assign w_bit_end  = (r_baud == BAUD_LAST);

  assign req0_ready  = w_idle & ~rst & w_any & ~w_sel;
  assign req1_ready  = w_idle & ~rst & w_any & w_sel;
  assign tx          = r_tx;
  assign busy        = r_busy;
  assign grant_id    = r_gid;
  assign o_dbg_state = r_state;

  always_comb begin
    w_nxt_state = r_state;
    w_nxt_baud  = w_bit_end ? '0 : r_baud + 1'b1;
    w_nxt_bit   = r_bit;
    w_nxt_shift = r_shift;
    w_nxt_par   = r_par;
    w_nxt_rr    = r_rr;
    w_nxt_tx    = r_tx;
    w_nxt_busy  = r_busy;
    w_nxt_gid   = r_gid;
    case (r_state)
      S_IDLE: begin
        w_nxt_baud = '0;
        if (w_any) begin
          w_nxt_state = S_START;
          w_nxt_shift = w_sel_data;
          w_nxt_gid   = w_sel;
          w_nxt_rr    = ~w_sel;
          w_nxt_tx    = 1'b0;
          w_nxt_busy  = 1'b1;
          w_nxt_par   = 1'b0;
          w_nxt_bit   = 3'd0;
        end
      end
      S_START: begin
        if (w_bit_end) begin
          w_nxt_state = S_DATA;
          w_nxt_tx    = r_shift[0];
          w_nxt_bit   = 3'd0;
        end
      end
      S_DATA: begin
        // r_shift[0] is the bit currently on the line; fold it into parity as it ends.
        if (w_bit_end) begin
          w_nxt_par = r_par ^ r_shift[0];
          if (r_bit == 3'd7) begin
            if (PARITY_EN) begin
              w_nxt_state = S_PARITY;
              w_nxt_tx    = r_par ^ r_shift[0];
            end else begin
              w_nxt_state = S_STOP;
              w_nxt_tx    = 1'b1;
            end
          end else begin
            w_nxt_shift = {1'b0, r_shift[7:1]};
            w_nxt_tx    = r_shift[1];
            w_nxt_bit   = r_bit + 3'd1;
          end
        end
      end
      S_PARITY: begin
        if (w_bit_end) begin
          w_nxt_state = S_STOP;
          w_nxt_tx    = 1'b1;
        end
      end
      S_STOP: begin
        if (w_bit_end) begin
          w_nxt_state = S_IDLE;
          w_nxt_tx    = 1'b1;
          w_nxt_busy  = 1'b0;
        end
      end
      default: begin
        w_nxt_state = S_IDLE;
        w_nxt_tx    = 1'b1;
        w_nxt_busy  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge inp_clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_baud  <= '0;
      r_bit   <= 3'd0;
      r_shift <= 8'd0;
      r_par   <= 1'b0;
      r_rr    <= 1'b0;
      r_tx    <= 1'b1;
      r_busy  <= 1'b0;
      r_gid   <= 1'b0;
    end else begin
      r_state <= w_nxt_state;
      r_baud  <= w_nxt_baud;
      r_bit   <= w_nxt_bit;
      r_shift <= w_nxt_shift;
      r_par   <= w_nxt_par;
      r_rr    <= w_nxt_rr;
      r_tx    <= w_nxt_tx;
      r_busy  <= w_nxt_busy;
      r_gid   <= w_nxt_gid;
    end
  end

endmodule

// File: tb/tb_uart_tx_arb.sv
// Bench for uart_tx_arb: three instances (C=8, C=8 with parity, C=2) with a
// frame monitor that decodes tx and compares against queued expected bytes.
module tb_uart_tx_arb;

  logic       inp_clk = 1'b0;
  logic       rst;
  int         cyc = 0;
  int         n_checks = 0;
  int         n_err = 0;

  // instance 0: C=8, no parity
  logic       m_v0, m_v1, m_r0, m_r1, m_tx, m_busy, m_gid;
  logic [7:0] m_d0, m_d1;
  logic [2:0] m_st;
  // instance 1: C=8, even parity
  logic       p_v0, p_v1, p_r0, p_r1, p_tx, p_busy, p_gid;
  logic [7:0] p_d0, p_d1;
  logic [2:0] p_st;
  // instance 2: C=2, no parity
  logic       c_v0, c_v1, c_r0, c_r1, c_tx, c_busy, c_gid;
  logic [7:0] c_d0, c_d1;
  logic [2:0] c_st;

  // expected frames: {instance[1:0], grant id, byte}
  logic [10:0] exp_q[$];
  int          start_q[$];

  logic [127:0] smp [3];
  int           nsmp [3];
  logic         prev_b [3];
  logic         last_gid [3];

  typedef struct {
    logic       v0;
    logic       v1;
    logic [7:0] d0;
    logic [7:0] d1;
    logic       exp_id;
  } vec_t;
  vec_t tbl [5];

  uart_tx_arb #(.CLKS_PER_BIT(8), .PARITY_EN(1'b0)) u_dut (
    .inp_clk(inp_clk), .rst(rst),
    .req0_valid(m_v0), .req0_data(m_d0), .req0_ready(m_r0),
    .req1_valid(m_v1), .req1_data(m_d1), .req1_ready(m_r1),
    .tx(m_tx), .busy(m_busy), .grant_id(m_gid), .o_dbg_state(m_st));

  uart_tx_arb #(.CLKS_PER_BIT(8), .PARITY_EN(1'b1)) u_par (
    .inp_clk(inp_clk), .rst(rst),
    .req0_valid(p_v0), .req0_data(p_d0), .req0_ready(p_r0),
    .req1_valid(p_v1), .req1_data(p_d1), .req1_ready(p_r1),
    .tx(p_tx), .busy(p_busy), .grant_id(p_gid), .o_dbg_state(p_st));

  uart_tx_arb #(.CLKS_PER_BIT(2), .PARITY_EN(1'b0)) u_c2 (
    .inp_clk(inp_clk), .rst(rst),
    .req0_valid(c_v0), .req0_data(c_d0), .req0_ready(c_r0),
    .req1_valid(c_v1), .req1_data(c_d1), .req1_ready(c_r1),
    .tx(c_tx), .busy(c_busy), .grant_id(c_gid), .o_dbg_state(c_st));

  // clock / reset-independent cycle counter
  always #5 inp_clk = ~inp_clk;
  always @(posedge inp_clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", name, got, exp, cyc);
    end
  endtask

  function automatic logic busy_of(input int inst);
    case (inst)
      0: busy_of = m_busy;
      1: busy_of = p_busy;
      default: busy_of = c_busy;
    endcase
  endfunction

  task automatic check_frame(input int inst, input int c, input bit par);
    int          nb;
    int          bad;
    logic [10:0] ev;
    logic [10:0] e;
    logic [10:0] dec;
    nb = par ? 11 : 10;
    chk($sformatf("frame_len[%0d]", inst), nsmp[inst], nb * c);
    if (exp_q.size() == 0) begin
      n_checks++;
      n_err++;
      $display("FAIL unexpected_frame[%0d]: got a frame, expected none at cycle %0d", inst, cyc);
    end else begin
      ev = exp_q.pop_front();
      chk($sformatf("frame_inst[%0d]", inst), inst, ev[10:9]);
      chk($sformatf("grant_id[%0d]", inst), last_gid[inst], ev[8]);
      e = '0;
      e[8:1] = ev[7:0];
      if (par) e[9] = ^ev[7:0];
      e[nb-1] = 1'b1;
      dec = '0;
      bad = 0;
      for (int k = 0; k < nb; k++) begin
        dec[k] = smp[inst][k*c + c/2];
        for (int j = 0; j < c; j++)
          if (smp[inst][k*c + j] !== e[k]) bad++;
      end
      chk($sformatf("frame_bits[%0d]", inst), dec, e);
      chk($sformatf("bit_stable[%0d]", inst), bad, 0);
    end
  endtask

  // monitor: collect one tx sample per cycle while busy; discard on reset
  task automatic mon_step(input int inst, input int c, input bit par,
                          input logic b, input logic t, input logic gid);
    if (rst) begin
      prev_b[inst] = 1'b0;
      nsmp[inst]   = 0;
    end else begin
      if (b) begin
        if (!prev_b[inst]) start_q.push_back(cyc);
        if (nsmp[inst] < 128) smp[inst][nsmp[inst]] = t;
        nsmp[inst]++;
        last_gid[inst] = gid;
      end else if (prev_b[inst]) begin
        check_frame(inst, c, par);
        nsmp[inst] = 0;
      end
      prev_b[inst] = b;
    end
  endtask

  always @(negedge inp_clk) begin
    mon_step(0, 8, 1'b0, m_busy, m_tx, m_gid);
    mon_step(1, 8, 1'b1, p_busy, p_tx, p_gid);
    mon_step(2, 2, 1'b0, c_busy, c_tx, c_gid);
  end

  task automatic wait_low(input int inst);
    int n;
    n = 0;
    @(negedge inp_clk);
    while (busy_of(inst) && n < 3000) begin
      @(negedge inp_clk);
      n++;
    end
    if (busy_of(inst)) begin
      n_checks++;
      n_err++;
      $display("FAIL busy_timeout[%0d]: busy still 1, expected 0 within 3000 cycles", inst);
    end
  endtask

  task automatic wait_starts(input int cnt);
    int n;
    n = 0;
    while (start_q.size() < cnt && n < 3000) begin
      @(negedge inp_clk);
      n++;
    end
    chk("start_count", start_q.size(), cnt);
  endtask

  task automatic drive_main(input logic v0, input logic v1, input logic [7:0] d0, input logic [7:0] d1);
    m_v0 = v0; m_v1 = v1; m_d0 = d0; m_d1 = d1;
  endtask

  initial begin
    for (int i = 0; i < 3; i++) begin
      smp[i] = '0; nsmp[i] = 0; prev_b[i] = 1'b0; last_gid[i] = 1'b0;
    end
    tbl[0] = '{v0: 1'b1, v1: 1'b0, d0: 8'hA5, d1: 8'h00, exp_id: 1'b0};
    tbl[1] = '{v0: 1'b1, v1: 1'b1, d0: 8'h12, d1: 8'h34, exp_id: 1'b1};
    tbl[2] = '{v0: 1'b1, v1: 1'b1, d0: 8'hFF, d1: 8'h00, exp_id: 1'b0};
    tbl[3] = '{v0: 1'b0, v1: 1'b1, d0: 8'h00, d1: 8'h80, exp_id: 1'b1};
    tbl[4] = '{v0: 1'b1, v1: 1'b0, d0: 8'h01, d1: 8'hEE, exp_id: 1'b0};

    rst = 1'b1;
    drive_main(1'b1, 1'b0, 8'h11, 8'h22);
    p_v0 = 0; p_v1 = 0; p_d0 = 0; p_d1 = 0;
    c_v0 = 0; c_v1 = 0; c_d0 = 0; c_d1 = 0;
    repeat (3) @(negedge inp_clk);
    #1;
    chk("rst_tx", m_tx, 1);
    chk("rst_busy", m_busy, 0);
    chk("rst_grant_id", m_gid, 0);
    chk("rst_ready0", m_r0, 0);
    chk("rst_state", m_st, 0);
    m_v0 = 1'b0;
    #1 rst = 1'b0;

    // only requester 1 after reset: granted at once
    @(negedge inp_clk);
    drive_main(1'b0, 1'b1, 8'h00, 8'hC3);
    #1;
    chk("solo1_ready1", m_r1, 1);
    chk("solo1_ready0", m_r0, 0);
    exp_q.push_back({2'd0, 1'b1, 8'hC3});
    @(posedge inp_clk); #1 m_v1 = 1'b0;
    @(negedge inp_clk);
    chk("solo1_grant_id", m_gid, 1);
    chk("solo1_ready_drop", m_r1, 0);
    wait_low(0);

    // both held: grants 0,1,0,1 at 81-cycle spacing (rr returned to 0 above)
    start_q.delete();
    drive_main(1'b1, 1'b1, 8'h55, 8'h0F);
    for (int i = 0; i < 4; i++) exp_q.push_back({2'd0, i[0], (i[0] ? 8'h0F : 8'h55)});
    wait_starts(4);
    drive_main(1'b0, 1'b0, 8'h00, 8'h00);
    wait_low(0);
    if (start_q.size() >= 4)
      for (int i = 1; i < 4; i++)
        chk($sformatf("b2b_spacing%0d", i), start_q[i] - start_q[i-1], 81);

    // table-driven single grants
    for (int i = 0; i < 5; i++) begin
      drive_main(tbl[i].v0, tbl[i].v1, tbl[i].d0, tbl[i].d1);
      #1;
      chk($sformatf("tbl%0d_ready0", i), m_r0, !tbl[i].exp_id);
      chk($sformatf("tbl%0d_ready1", i), m_r1, tbl[i].exp_id);
      exp_q.push_back({2'd0, tbl[i].exp_id, (tbl[i].exp_id ? tbl[i].d1 : tbl[i].d0)});
      @(posedge inp_clk); #1 drive_main(1'b0, 1'b0, 8'h00, 8'h00);
      @(negedge inp_clk);
      chk($sformatf("tbl%0d_busy", i), m_busy, 1);
      chk($sformatf("tbl%0d_tx_start", i), m_tx, 0);
      wait_low(0);
    end

    // reset during data bit 3, requester 1 held throughout
    drive_main(1'b1, 1'b0, 8'h00, 8'h00);
    @(posedge inp_clk); #1 drive_main(1'b0, 1'b1, 8'h00, 8'h5A);
    repeat (34) @(negedge inp_clk);
    chk("pre_rst_tx", m_tx, 0);
    #1 rst = 1'b1;
    #1;
    chk("async_rst_tx", m_tx, 1);
    chk("async_rst_busy", m_busy, 0);
    chk("async_rst_ready1", m_r1, 0);
    @(negedge inp_clk);
    #1 rst = 1'b0;
    #1;
    chk("post_rst_state", m_st, 0);
    m_v0 = 1'b1; m_d0 = 8'hAA;
    #1;
    chk("post_rst_rr_ready0", m_r0, 1);
    chk("post_rst_rr_ready1", m_r1, 0);
    m_v0 = 1'b0;
    #1;
    chk("post_rst_ready1", m_r1, 1);
    exp_q.push_back({2'd0, 1'b1, 8'h5A});
    @(posedge inp_clk); #1 m_v1 = 1'b0;
    wait_low(0);

    // parity instance: 0x07 then two random bytes
    for (int i = 0; i < 3; i++) begin
      logic [7:0] b;
      b = (i == 0) ? 8'h07 : 8'($urandom_range(0, 255));
      p_v0 = 1'b1; p_d0 = b;
      #1 chk($sformatf("par%0d_ready0", i), p_r0, 1);
      exp_q.push_back({2'd1, 1'b0, b});
      @(posedge inp_clk); #1 p_v0 = 1'b0;
      wait_low(1);
    end

    // C=2: 0x00 held, second accept 21 cycles after the first
    start_q.delete();
    c_v0 = 1'b1; c_d0 = 8'h00;
    exp_q.push_back({2'd2, 1'b0, 8'h00});
    exp_q.push_back({2'd2, 1'b0, 8'h00});
    wait_starts(2);
    c_v0 = 1'b0;
    wait_low(2);
    if (start_q.size() >= 2) chk("c2_spacing", start_q[1] - start_q[0], 21);

    repeat (4) @(negedge inp_clk);
    chk("exp_q_empty", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/uart_tx_arb.md
# uart_tx_arb

Two-requester UART transmit controller. It arbitrates round-robin between two byte sources, then serialises the granted byte onto `tx` as one 8N1 frame, or 8E1 when parity is enabled. Bit timing comes from an internal baud-enable counter rather than a derived clock, so the entire block runs on `inp_clk`. It sits between the system-side byte producers and the UART pin, and replaces any clock-divided transmit path.

## Interface
- `CLKS_PER_BIT`, default 8: `inp_clk` cycles per serial bit; legal values ≥ 2.
- `PARITY_EN`, default 0: 1 inserts an even-parity bit between the data bits and the stop bit.
- `inp_clk` in 1: system clock; all state updates on its rising edge.
- `rst` in 1: reset, asynchronous, active-high.
- `req0_valid` in 1: requester 0 has a byte.
- `req0_data` in 8: requester 0 byte; held stable while `req0_valid`=1 and not yet accepted.
- `req0_ready` out 1: combinational grant/accept strobe to requester 0.
- `req1_valid`, `req1_data`, `req1_ready`: same as the requester 0 signals, for requester 1.
- `tx` out 1: registered serial line; idles high.
- `busy` out 1: registered; high while a frame is on the line.
- `grant_id` out 1: registered; id of the requester whose frame is in progress or was last sent.

## Operation
- States: IDLE, START, DATA, PARITY, STOP.
- Internal registers:
  - baud counter, width $clog2(CLKS_PER_BIT), range 0..CLKS_PER_BIT-1
  - bit index, 3 bits
  - shift register, 8 bits
  - parity accumulator
  - round-robin pointer `rr`, 1 bit
- Reset values: `tx`=1, `busy`=0, `grant_id`=0, `rr`=0, state IDLE, counters 0. Both readys are 0 while `rst`=1.
- Arbitration happens only in IDLE:
  - If only one valid is high, that requester is selected.
  - If both are high, requester `rr` is selected.
  - The selected requester's ready is 1 combinationally; the other ready is 0.
  - Outside IDLE, both readys are 0.
- Handshake is `valid && ready` at a rising edge. On that edge:
  - data is latched into the shift register
  - `grant_id` takes the selected id
  - `rr` takes the inverse of the selected id
  - state goes to START; `tx` becomes 0 and `busy` becomes 1
  - the baud counter is cleared
- Each of START, each DATA bit, PARITY and STOP lasts exactly CLKS_PER_BIT cycles. The bit advances when the baud counter equals CLKS_PER_BIT-1, and the counter wraps to 0 at that point.
- DATA sends LSB first, 8 bits; then goes to PARITY if `PARITY_EN`=1, otherwise to STOP.
- PARITY drives `tx` = XOR of the 8 latched bits (even parity).
- STOP drives `tx`=1. At the end of STOP the state returns to IDLE and `busy` becomes 0.
- The IDLE state is entered for at least one cycle between frames; no acceptance occurs inside STOP.
- A requester dropping valid before it is granted is legal; no transfer occurs.
- Changes to request inputs mid-frame are ignored.
- `rst` asserted at any time:
  - `tx` goes to 1 and `busy` to 0 immediately (asynchronously)
  - the frame in progress is abandoned
  - `rr` returns to 0; no partial byte is resent

## Timing
- Accept edge at E:
  - `tx`=0 during cycles E+1 .. E+C, where C = CLKS_PER_BIT.
  - Data bit i is driven during cycles E+1+(i+1)·C .. E+(i+2)·C.
  - Stop bit occupies the last C cycles of the frame.
- Frame length is 10·C cycles, or 11·C with parity. `busy`=1 for exactly that many cycles.
- Earliest next acceptance is at edge E+10·C+1 (or E+11·C+1 with parity). The back-to-back frame period is therefore 10·C+1 (or 11·C+1) cycles.
- Ready-to-line latency is 1 cycle: the start bit appears on the edge that accepts the byte.
- `tx` is glitch-free because it is driven directly from a flop.

## Test plan
- Single byte, C=8, `req0_data`=0xA5:
  - `req0_ready` is high for 1 cycle.
  - `tx` per 8-cycle bit is 0,1,0,1,0,0,1,0,1,1.
  - `busy` is high for 80 cycles; `grant_id`=0.
- Both requesters held valid from reset, req0=0x55, req1=0x0F:
  - Grants alternate 0,1,0,1.
  - Frame starts are spaced 81 cycles apart.
  - Each frame carries its own requester's byte.
- Only `req1_valid` after reset (`rr`=0):
  - Requester 1 is granted immediately; `grant_id`=1 and `rr` becomes 0.
- `PARITY_EN`=1, byte 0x07:
  - The 11-bit frame is 0, 1,1,1,0,0,0,0,0, parity bit 1, stop bit 1.
  - `busy` is high for 88 cycles.
- `rst` pulsed during data bit 3:
  - `tx`=1 and `busy`=0 in the same cycle.
  - After release, state is IDLE, `rr`=0, and a held `req1_valid` alone is granted.
- C=2, byte 0x00: `tx` is low for 18 cycles, then high for 2; the next accept occurs on the 21st cycle.
